mem_stream_arbiter: RTL and testbench
=====================================

// Module: mem_stream_arbiter
// PURPOSE
//  Two-requester AXI-Stream arbiter sharing the single write port of the stream memory.
//  Grants whole packets using round-robin, locks the grant until tlast, and forces tlast at MAX_BEATS.
//  Registers one output beat toward the memory and reports grant state and per-requester packet counts.
// PARAMETERS
//  DATA_WIDTH  32    stream data width; tstrb is DATA_WIDTH/8 bits
//  MAX_BEATS   256   max beats per granted packet before forced tlast (1..2^BEAT_WIDTH-1)
//  BEAT_WIDTH  12    beat counter width
//  CNT_WIDTH   16    packet counter width (wraps)
// PORTS
//  axis_aclk        in   1              single clock, rising edge
//  axis_aresetn     in   1              async active-low reset
//  s00_axis_tdata   in   DATA_WIDTH     requester 0 data
//  s00_axis_tstrb   in   DATA_WIDTH/8   requester 0 strobe, passed through unchanged
//  s00_axis_tvalid  in   1              requester 0 valid
//  s00_axis_tlast   in   1              requester 0 end of packet
//  s00_axis_tready  out  1              requester 0 ready
//  s01_axis_*       same as s00_axis_*  requester 1
//  m00_axis_tdata   out  DATA_WIDTH     to memory write data
//  m00_axis_tstrb   out  DATA_WIDTH/8   to memory strobe
//  m00_axis_tvalid  out  1              to memory valid
//  m00_axis_tlast   out  1              to memory last (source tlast OR forced)
//  m00_axis_tready  in   1              memory ready
//  grant            out  2              one-hot active grant; 2'b00 when IDLE
//  pkt_cnt0         out  CNT_WIDTH      packets completed from s00
//  pkt_cnt1         out  CNT_WIDTH      packets completed from s01
// BEHAVIOUR
//  Reset (async, while axis_aresetn=0):
//  - State is IDLE and last_grant=1, so s00 wins the first tie.
//  - All outputs are 0: tready, m00 tdata/tstrb/tvalid/tlast, grant, pkt_cnt*, beat_cnt.
//  - An in-flight beat or packet is dropped, with no partial completion.
//  FSM states: IDLE, GNT0, GNT1.
//  - IDLE, s00 valid only: go to GNT0.
//  - IDLE, s01 valid only: go to GNT1.
//  - IDLE, both valid: grant the requester that is not last_grant, then update last_grant.
//  - IDLE, neither valid: stay in IDLE.
//  - The grant decision costs one cycle; tready is never asserted in IDLE.
//  - GNTx goes to IDLE on the cycle a beat is accepted with (src tlast | beat_cnt==MAX_BEATS-1).
//  - Exactly one IDLE cycle separates consecutive packets.
//  Handshake:
//  - sXX_tready = (state==GNTx) & (~m00_tvalid | m00_tready).
//  - Ungranted tready is 0.
//  - An accept occurs on sXX_tvalid & sXX_tready.
//  - On accept, the m00 register loads tdata, tstrb, tlast_out and sets tvalid=1.
//  - Latency is one cycle from input accept to m00_tvalid.
//  - m00_tvalid clears on m00_tready & no new accept.
//  - While m00_tvalid=1 and m00_tready=0, m00 outputs hold stable (AXIS rule).
//  - Simultaneous drain and accept: the register reloads and tvalid stays 1 (full throughput).
//  beat_cnt:
//  - Increments per accepted beat in GNTx.
//  - Clears on the packet-ending accept and in IDLE.
//  - Forced tlast: beat MAX_BEATS is sent with m00_tlast=1 and the grant is released.
//  - The source's remaining beats re-arbitrate as a new packet.
//  pkt_cntX: +1 on the packet-ending accept from X (forced or real); wraps at 2^CNT_WIDTH.
//  Requester tvalid dropping mid-packet: the grant holds and no timeout applies.
//  grant mirrors the state combinationally from the state register.
// TESTING
//  1. Reset, s00 sends 3 beats (A1..A3, tlast on A3), m00_tready=1 -> m00 sees A1..A3 one cycle after each accept; pkt_cnt0=1; grant returns to 00.
//  2. s00 and s01 both valid with 2-beat packets, repeated 4x -> order s00,s01,s00,s01; pkt_cnt0=pkt_cnt1=2; no interleaved beats within a packet.
//  3. MAX_BEATS=4, s01 sends 6 beats with tlast on beat 6 -> m00_tlast on beats 4 and 6; pkt_cnt1=2.
//  4. m00_tready held 0 for 5 cycles mid-packet -> m00 data/tlast held stable, sXX_tready=0; no beat lost or duplicated after release.
//  5. Assert axis_aresetn=0 on beat 2 of a 4-beat packet -> all outputs 0 immediately; after release s00 wins the first tie.
//  6. s00 tvalid gaps (1 of every 2 cycles) while s01 valid -> s01 not granted until s00 tlast accepted.

Source files
------------

// File: rtl/mem_stream_arbiter.sv
// Two-requester AXI-Stream arbiter feeding the stream memory write port.
// Whole-packet round-robin grants, forced tlast at MAX_BEATS, one registered output beat.
module mem_stream_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256,
  parameter int BEAT_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  input  logic                    s01_axis_tlast,
  output logic                    s01_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic [1:0]              grant,
  output logic [CNT_WIDTH-1:0]    pkt_cnt0,
  output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic                    last_grant_reg, last_grant_next;
  logic [BEAT_WIDTH-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [DATA_WIDTH-1:0]   tdata_reg;
  logic [STRB_WIDTH-1:0]   tstrb_reg;
  logic                    tvalid_reg;
  logic                    tlast_reg;
  logic [CNT_WIDTH-1:0]    pkt_cnt0_reg, pkt_cnt1_reg;

  logic                    can_load;
  logic                    accept0, accept1, accept;
  logic [DATA_WIDTH-1:0]   src_data;
  logic [STRB_WIDTH-1:0]   src_strb;
  logic                    src_last;
  logic                    beat_limit;
  logic                    last_out;
  logic                    pkt_end;

  // The output register can take a new beat when empty or draining this cycle.
  assign can_load        = ~tvalid_reg | m00_axis_tready;
  assign s00_axis_tready = (state_reg == GNT0) & can_load;
  assign s01_axis_tready = (state_reg == GNT1) & can_load;
  assign accept0         = s00_axis_tvalid & s00_axis_tready;
  assign accept1         = s01_axis_tvalid & s01_axis_tready;
  assign accept          = accept0 | accept1;

  assign src_data   = (state_reg == GNT1) ? s01_axis_tdata : s00_axis_tdata;
  assign src_strb   = (state_reg == GNT1) ? s01_axis_tstrb : s00_axis_tstrb;
  assign src_last   = (state_reg == GNT1) ? s01_axis_tlast : s00_axis_tlast;
  assign beat_limit = (beat_cnt_reg == BEAT_WIDTH'(MAX_BEATS - 1));
  assign last_out   = src_last | beat_limit;
  assign pkt_end    = accept & last_out;

  assign grant = {state_reg == GNT1, state_reg == GNT0};

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    case (state_reg)
      IDLE: begin
        beat_cnt_next = '0;
        // On a tie, the requester that was not granted last wins.
        if (s00_axis_tvalid & (~s01_axis_tvalid | last_grant_reg)) begin
          state_next      = GNT0;
          last_grant_next = 1'b0;
        end else if (s01_axis_tvalid) begin
          state_next      = GNT1;
          last_grant_next = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (pkt_end) begin
          state_next    = IDLE;
          beat_cnt_next = '0;
        end else if (accept) begin
          beat_cnt_next = beat_cnt_reg + BEAT_WIDTH'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        beat_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      tdata_reg  <= '0;
      tstrb_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
    end else if (accept) begin
      tdata_reg  <= src_data;
      tstrb_reg  <= src_strb;
      tvalid_reg <= 1'b1;
      tlast_reg  <= last_out;
    end else if (m00_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      pkt_cnt0_reg <= '0;
      pkt_cnt1_reg <= '0;
    end else begin
      if (pkt_end && state_reg == GNT0) pkt_cnt0_reg <= pkt_cnt0_reg + CNT_WIDTH'(1);
      if (pkt_end && state_reg == GNT1) pkt_cnt1_reg <= pkt_cnt1_reg + CNT_WIDTH'(1);
    end
  end

  assign m00_axis_tdata  = tdata_reg;
  assign m00_axis_tstrb  = tstrb_reg;
  assign m00_axis_tvalid = tvalid_reg;
  assign m00_axis_tlast  = tlast_reg;
  assign pkt_cnt0        = pkt_cnt0_reg;
  assign pkt_cnt1        = pkt_cnt1_reg;

endmodule

// File: tb/tb_mem_stream_arbiter.sv
// Directed bench for mem_stream_arbiter (MAX_BEATS=4): queued packet sources,
// an output log, and hand-computed expected streams and counters.
module tb_mem_stream_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s0_data = '0, s1_data = '0;
  logic [3:0]  s0_strb = '0, s1_strb = '0;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic        s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_ready, s1_ready;
  logic [31:0] m_data;
  logic [3:0]  m_strb;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [1:0]  grant;
  logic [15:0] pkt_cnt0, pkt_cnt1;

  beat_t       q0[$], q1[$], out_q[$];
  logic        gap0 = 1'b0;
  logic        a0, a1, prev_acc;
  logic [31:0] prev_data;
  int          acc_cnt0, acc_cnt1;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_stream_arbiter #(
    .DATA_WIDTH(32), .MAX_BEATS(4), .BEAT_WIDTH(12), .CNT_WIDTH(16)
  ) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s00_axis_tdata(s0_data), .s00_axis_tstrb(s0_strb), .s00_axis_tvalid(s0_valid),
    .s00_axis_tlast(s0_last), .s00_axis_tready(s0_ready),
    .s01_axis_tdata(s1_data), .s01_axis_tstrb(s1_strb), .s01_axis_tvalid(s1_valid),
    .s01_axis_tlast(s1_last), .s01_axis_tready(s1_ready),
    .m00_axis_tdata(m_data), .m00_axis_tstrb(m_strb), .m00_axis_tvalid(m_valid),
    .m00_axis_tlast(m_last), .m00_axis_tready(m_ready),
    .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_pkt(input int who, input int n, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = base + 32'(i);
      b.strb = b.data[3:0];
      b.last = (i == n - 1);
      if (who == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  // One clock: sample at negedge, then update sources just after posedge.
  task automatic tick();
    @(negedge clk);
    a0 = s0_valid && s0_ready;
    a1 = s1_valid && s1_ready;
    if (prev_acc) begin
      check_value("latency_valid", 64'(m_valid), 64'(1'b1));
      check_value("latency_data", 64'(m_data), 64'(prev_data));
    end
    if (m_valid && m_ready) out_q.push_back({m_data, m_strb, m_last});
    prev_acc  = a0 | a1;
    prev_data = a0 ? s0_data : s1_data;
    if (a0) acc_cnt0++;
    if (a1) acc_cnt1++;
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    if (gap0 && a0) s0_valid = 1'b0;
    else if (q0.size() > 0) begin
      s0_valid = 1'b1;
      {s0_data, s0_strb, s0_last} = q0[0];
    end else s0_valid = 1'b0;
    if (q1.size() > 0) begin
      s1_valid = 1'b1;
      {s1_data, s1_strb, s1_last} = q1[0];
    end else s1_valid = 1'b0;
  endtask

  task automatic clear_bench();
    q0.delete(); q1.delete(); out_q.delete();
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1; gap0 = 1'b0;
    prev_acc = 1'b0; acc_cnt0 = 0; acc_cnt1 = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_bench();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic check_stream(input string tag, input logic [31:0] ed [8], input int n,
                              input logic [7:0] el);
    logic [31:0] d;
    check_value({tag, "_len"}, 64'(out_q.size()), 64'(n));
    for (int i = 0; i < n && i < out_q.size(); i++) begin
      d = ed[i];
      check_value($sformatf("%s_data%0d", tag, i), 64'(out_q[i].data), 64'(d));
      check_value($sformatf("%s_strb%0d", tag, i), 64'(out_q[i].strb), 64'(d[3:0]));
      check_value($sformatf("%s_last%0d", tag, i), 64'(out_q[i].last), 64'(el[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    prev_acc = 1'b0; acc_cnt0 = 0; acc_cnt1 = 0;
    // Reset state with both requesters valid
    s0_valid = 1'b1; s1_valid = 1'b1;
    #12;
    check_value("rst_m_valid", 64'(m_valid), 64'(0));
    check_value("rst_m_data", 64'(m_data), 64'(0));
    check_value("rst_m_strb", 64'(m_strb), 64'(0));
    check_value("rst_m_last", 64'(m_last), 64'(0));
    check_value("rst_grant", 64'(grant), 64'(0));
    check_value("rst_s0_ready", 64'(s0_ready), 64'(0));
    check_value("rst_s1_ready", 64'(s1_ready), 64'(0));
    check_value("rst_pkt_cnt0", 64'(pkt_cnt0), 64'(0));
    check_value("rst_pkt_cnt1", 64'(pkt_cnt1), 64'(0));

    // Single 3-beat packet from s00
    do_reset();
    add_pkt(0, 3, 32'hA000_0001);
    repeat (10) tick();
    check_stream("t1", '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 0, 0, 0, 0, 0}, 3, 8'b100);
    check_value("t1_pkt_cnt0", 64'(pkt_cnt0), 64'(1));
    check_value("t1_pkt_cnt1", 64'(pkt_cnt1), 64'(0));
    check_value("t1_grant", 64'(grant), 64'(0));

    // Both requesters, two 2-beat packets each
    do_reset();
    add_pkt(0, 2, 32'hA000_0011); add_pkt(0, 2, 32'hA000_0021);
    add_pkt(1, 2, 32'hB000_0011); add_pkt(1, 2, 32'hB000_0021);
    repeat (20) tick();
    check_stream("t2", '{32'hA000_0011, 32'hA000_0012, 32'hB000_0011, 32'hB000_0012,
                         32'hA000_0021, 32'hA000_0022, 32'hB000_0021, 32'hB000_0022},
                 8, 8'b1010_1010);
    check_value("t2_pkt_cnt0", 64'(pkt_cnt0), 64'(2));
    check_value("t2_pkt_cnt1", 64'(pkt_cnt1), 64'(2));

    // Forced tlast after 4 beats of a 6-beat packet
    do_reset();
    add_pkt(1, 6, 32'hB000_0031);
    repeat (15) tick();
    check_stream("t3", '{32'hB000_0031, 32'hB000_0032, 32'hB000_0033, 32'hB000_0034,
                         32'hB000_0035, 32'hB000_0036, 0, 0}, 6, 8'b0010_1000);
    check_value("t3_pkt_cnt1", 64'(pkt_cnt1), 64'(2));
    check_value("t3_pkt_cnt0", 64'(pkt_cnt0), 64'(0));

    // Output back-pressure for 5 cycles mid-packet
    do_reset();
    add_pkt(0, 4, 32'hA000_0041);
    guard = 0;
    while (out_q.size() < 1 && guard < 20) begin tick(); guard++; end
    check_value("t4_first_out_timeout", 64'(guard < 20), 64'(1));
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check_value("t4_hold_valid", 64'(m_valid), 64'(1));
      check_value("t4_hold_data", 64'(m_data), 64'(32'hA000_0042));
      check_value("t4_hold_last", 64'(m_last), 64'(0));
      check_value("t4_s0_ready", 64'(s0_ready), 64'(0));
    end
    m_ready = 1'b1;
    repeat (10) tick();
    check_stream("t4", '{32'hA000_0041, 32'hA000_0042, 32'hA000_0043, 32'hA000_0044,
                         0, 0, 0, 0}, 4, 8'b1000);
    check_value("t4_pkt_cnt0", 64'(pkt_cnt0), 64'(1));

    // Asynchronous reset on beat 2 of a 4-beat packet
    do_reset();
    add_pkt(0, 4, 32'hA000_0051);
    guard = 0;
    while (acc_cnt0 < 2 && guard < 20) begin tick(); guard++; end
    check_value("t5_beat2_timeout", 64'(guard < 20), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check_value("t5_m_valid", 64'(m_valid), 64'(0));
    check_value("t5_m_data", 64'(m_data), 64'(0));
    check_value("t5_m_last", 64'(m_last), 64'(0));
    check_value("t5_grant", 64'(grant), 64'(0));
    check_value("t5_s0_ready", 64'(s0_ready), 64'(0));
    check_value("t5_pkt_cnt0", 64'(pkt_cnt0), 64'(0));
    clear_bench();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    add_pkt(0, 1, 32'hA000_0071);
    add_pkt(1, 1, 32'hB000_0071);
    repeat (10) tick();
    check_stream("t5", '{32'hA000_0071, 32'hB000_0071, 0, 0, 0, 0, 0, 0}, 2, 8'b11);
    check_value("t5_pkt_cnt0_after", 64'(pkt_cnt0), 64'(1));
    check_value("t5_pkt_cnt1_after", 64'(pkt_cnt1), 64'(1));

    // s00 valid gaps must not release the grant to s01
    do_reset();
    gap0 = 1'b1;
    add_pkt(0, 3, 32'hA000_0081);
    add_pkt(1, 2, 32'hB000_0081);
    repeat (3) tick();
    #1;
    check_value("t6_gap_s0_valid", 64'(s0_valid), 64'(0));
    check_value("t6_gap_grant", 64'(grant), 64'(2'b01));
    check_value("t6_gap_s1_ready", 64'(s1_ready), 64'(0));
    repeat (20) tick();
    check_stream("t6", '{32'hA000_0081, 32'hA000_0082, 32'hA000_0083, 32'hB000_0081,
                         32'hB000_0082, 0, 0, 0}, 5, 8'b1_0100);
    check_value("t6_pkt_cnt0", 64'(pkt_cnt0), 64'(1));
    check_value("t6_pkt_cnt1", 64'(pkt_cnt1), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
